bitwise_logic_pipe: RTL and testbench

BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

---
 rtl/bitwise_logic_pipe.sv | 103 ++++++++++
 tb/tb_bitwise_logic_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// rtl/bitwise_logic_pipe.sv - bitwise ALU feeding a 2-entry result FIFO with saturating transfer counter
// Optional: define BITWISE_LOGIC_PIPE_PARITY_EN to add out_par (per-entry XOR parity of the result).
module bitwise_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [2:0]       out_op,
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
  output logic             out_par,
`endif
  output logic [CNT_W-1:0] tx_count
);

  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] y_q [2];
  logic [2:0]       op_q [2];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res;
  logic             push, pop;

  assign out_valid = (occ_q != 2'd0);
  assign in_ready  = (occ_q < 2'd2) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_y     = y_q[rd_ptr_q];
  assign out_op    = op_q[rd_ptr_q];
  assign tx_count  = cnt_q;

  always_comb begin
    res = '0;
    case (in_op)
      3'd0: res = ~in_a;
      3'd1: res = in_a & in_b;
      3'd2: res = in_a | in_b;
      3'd3: res = ~(in_a & in_b);
      3'd4: res = ~(in_a | in_b);
      3'd5: res = in_a ^ in_b;
      3'd6: res = ~(in_a ^ in_b);
      default: res = in_a;
    endcase
  end

  // Simultaneous push and pop leaves occupancy untouched.
  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    cnt_d = cnt_q;
    if (pop && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        y_q[i]  <= '0;
        op_q[i] <= 3'd0;
      end
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      if (push) begin
        y_q[wr_ptr_q]  <= res;
        op_q[wr_ptr_q] <= in_op;
        wr_ptr_q       <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
  logic par_q [2];

  assign out_par = par_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q[0] <= 1'b0;
      par_q[1] <= 1'b0;
    end else if (push) begin
      par_q[wr_ptr_q] <= ^res;
    end
  end
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb/tb_bitwise_logic_pipe.sv - scoreboard bench for bitwise_logic_pipe (WIDTH=8, CNT_W=4)
module tb_bitwise_logic_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op;
  logic [CNT_W-1:0] tx_count;
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
  logic             out_par;
`endif

  bitwise_logic_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_op(out_op),
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
    .out_par(out_par),
`endif
    .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic [2:0]       op;
    logic             par;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every completed output transfer.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        errors++;
        $display("FAIL sb_unexpected: got y=%0h op=%0h expected nothing", out_y, out_op);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_y", 64'(out_y), 64'(e.y));
        chk("mon_op", 64'(out_op), 64'(e.op));
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
        chk("mon_par", 64'(out_par), 64'(e.par));
`endif
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] exp_y);
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      e.y = exp_y;
      e.op = op;
      e.par = ^exp_y;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  logic [7:0] exp30 [8];
  logic [7:0] y_hold;

  initial begin
    exp30[0] = 8'h0F; exp30[1] = 8'h30; exp30[2] = 8'hFC; exp30[3] = 8'hCF;
    exp30[4] = 8'h03; exp30[5] = 8'hCC; exp30[6] = 8'h33; exp30[7] = 8'hF0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_tx_count", 64'(tx_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // All eight ops back to back, latency 1.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'hF0, 8'h3C, 3'(i), exp30[i]);
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_op", 64'(out_op), 64'(i));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ops_empty", 64'(out_valid), 64'd0);
    chk("ops_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: two fill the FIFO, third waits for out_ready.
    out_ready = 1'b0;
    send(8'hA5, 8'h0F, 3'd1, 8'h05);
    send(8'hA5, 8'h0F, 3'd2, 8'hAF);
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h0F; in_op = 3'd5;
    @(negedge clk);
    chk("bp_third_blocked", 64'(in_ready), 64'd0);
    y_hold = out_y;
    @(posedge clk); #1;
    chk("bp_hold_y", 64'(out_y), 64'(y_hold));
    chk("bp_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    send(8'hA5, 8'h0F, 3'd5, 8'hAA);
    drain();

    // Simultaneous accept and output at occupancy 1.
    out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd0, 8'hED);
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(8'h12, 8'h34, 3'd6, 8'hD9);
    in_valid = 1'b0;
    chk("sim_occ1_valid", 64'(out_valid), 64'd1);
    chk("sim_occ1_op", 64'(out_op), 64'd6);
    drain();

    // Reset with occupancy 2 and in_valid held high.
    out_ready = 1'b0;
    send(8'h11, 8'h00, 3'd7, 8'h11);
    send(8'h22, 8'h00, 3'd7, 8'h22);
    in_valid = 1'b1; in_a = 8'h33; in_op = 3'd7;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_tx_count", 64'(tx_count), 64'd0);
    chk("rstmid_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 20 transfers saturate a 4-bit counter at 15.
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(i), 8'h00, 3'd7, 8'(i));
    drain();
    chk("sat_tx_count", 64'(tx_count), 64'd15);

`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
    out_ready = 1'b0;
    send(8'h07, 8'h00, 3'd7, 8'h07);
    in_valid = 1'b0;
    chk("par_odd", 64'(out_par), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(8'h03, 8'h00, 3'd7, 8'h03);
    in_valid = 1'b0;
    chk("par_even", 64'(out_par), 64'd0);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
